saph_int_stepper: RTL and testbench
===================================

// Module: saph_int_stepper
// PURPOSE
//   Parametrised successor of the rasterizer int incrementer: NUMBERS signed accumulators stepped
//   through ADDERS time-shared adders. Supports X steps, Y steps with row-start tracking, and restore.
//   Adds a valid/ready command handshake, a done pulse and optional saturation.
//   Feeds edge-function and attribute values to the rasterizer scan loop.
// PARAMETERS
//   WIDTH     16  bit width of each accumulator (signed two's complement)
//   NUMBERS   4   number of accumulators
//   ADDERS    2   number of adders; BANKS = ceil(NUMBERS/ADDERS), 1 <= ADDERS <= NUMBERS
//   SATURATE  0   1: clamp results to signed min/max; 0: wrap modulo 2^WIDTH
// PORTS
//   clk        in   1               core clock
//   rst        in   1               synchronous reset, active high
//   latch      in   1               load init/inc_x/inc_y; aborts any in-flight command
//   init       in   WIDTH[NUMBERS]  initial values
//   inc_x      in   WIDTH[NUMBERS]  X-step increments
//   inc_y      in   WIDTH[NUMBERS]  Y-step increments
//   cmd_valid  in   1               command request
//   cmd        in   2               0 STEP_X, 1 STEP_Y, 2 RESTORE, 3 NOP
//   cmd_ready  out  1               command accepted on posedge when cmd_valid && cmd_ready
//   done       out  1               one-cycle pulse: command complete, cur/row final
//   cur        out  WIDTH[NUMBERS]  current values (registered)
//   row        out  WIDTH[NUMBERS]  row-start values (registered)
// BEHAVIOUR
//   Reset: cur = 0, row = 0, increment registers = 0, state IDLE, bank = 0, done = 0.
//   cmd_ready = !rst && !latch && state==IDLE. cmd_ready is high in the done cycle.
//   Latch (priority over cmd; ignored during rst): cur <= init, row <= init, inc_x/inc_y registered.
//     State returns to IDLE, bank to 0, and no done is raised for an aborted command.
//   FSM IDLE -> BUSY on accept of STEP_X or STEP_Y. Opcode is registered at accept.
//   RESTORE and NOP complete in one cycle and stay IDLE. RESTORE does cur <= row; NOP changes nothing.
//     done is high in the cycle after accept.
//   BUSY, bank b = 0..BANKS-1: lanes i = b*ADDERS+k, for k < ADDERS and i < NUMBERS, are written at
//     the end of that cycle. Out-of-range lanes in the last partial bank are ignored.
//     STEP_X: cur[i] <= cur[i] + inc_x_reg[i].
//     STEP_Y: row[i] <= row[i] + inc_y_reg[i], and cur[i] <= the same sum.
//   After bank BANKS-1 is written: state IDLE, bank 0, done = 1 for exactly one cycle.
//   Latency: with accept at edge T, bank b is written at edge T+1+b and done is high after edge
//     T+BANKS. Back-to-back period is BANKS+1 cycles.
//   Mid-command, cur mixes updated and old banks. Consumers sample only when done=1.
//   Arithmetic: full-precision signed add at WIDTH+1 bits.
//     SATURATE=1: clamp to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. SATURATE=0: keep the low WIDTH bits.
//   cmd_valid while busy is not accepted. The requester holds it; no buffering.
//   Reset mid-command: everything returns to reset values the next cycle, and done stays 0.
// TESTING (WIDTH=8, NUMBERS=4, ADDERS=2 unless noted)
//   1 rst for 2 cycles, then release -> cur=row={0,0,0,0}, done=0, cmd_ready=1.
//   2 latch init={10,20,30,40}, inc_x={1,2,3,4}; STEP_X accepted at T
//     -> cur[0:1]={11,22} after T+1; cur={11,22,33,44} and done=1 after T+2; cmd_ready=0 in between.
//   3 After test 2 with inc_y={-5,0,5,100}: STEP_X, STEP_X, STEP_Y
//     -> row={5,20,35,-116 (wrap)}, cur=row. Then STEP_X, RESTORE -> cur=row, done 1 cycle after RESTORE.
//   4 SATURATE=1: init {120,-120,0,0}, inc_x {10,-10,0,0}, STEP_X -> cur {127,-128,0,0}.
//     SATURATE=0 -> cur {-126,126,0,0}.
//   5 latch asserted at T+1 of a STEP_X -> cur=row=init next cycle, no done pulse, cmd_ready=1 after.
//   6 ADDERS=3, NUMBERS=4: back-to-back STEP_X with cmd_valid held -> accepts every 3 cycles,
//     lane 3 written in bank 1, and lanes 4..5 produce no writes.

Source files
------------

// File: rtl/saph_int_stepper.sv
// saph_int_stepper
//   NUMBERS signed accumulators stepped through ADDERS time-shared adders.
//   STEP_X adds inc_x to cur; STEP_Y adds inc_y to row and copies the sum to
//   cur; RESTORE copies row to cur; NOP only pulses done. Wide commands are
//   processed one bank of ADDERS lanes per cycle. Results are wrapped or
//   clamped depending on SATURATE.
//
//   State table:
//     S_IDLE | waiting for a command; cmd_ready high
//     S_BUSY | stepping lanes bank by bank; bank_q selects the active lanes
//
// Ports
//   clk_i        core clock
//   rst_i        synchronous reset, active high
//   latch_i      load init/inc_x/inc_y; aborts any in-flight command
//   init_i       initial values, one per lane
//   inc_x_i      X-step increments
//   inc_y_i      Y-step increments
//   cmd_valid_i  command request
//   cmd_i        0 STEP_X, 1 STEP_Y, 2 RESTORE, 3 NOP
//   cmd_ready_o  command accepted when cmd_valid_i && cmd_ready_o at posedge
//   done_o       one-cycle pulse: command complete, cur/row final
//   cur_o        current values
//   row_o        row-start values
module saph_int_stepper #(
    parameter int WIDTH    = 16,
    parameter int NUMBERS  = 4,
    parameter int ADDERS   = 2,
    parameter int SATURATE = 0
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            latch_i,
    input  logic [NUMBERS-1:0][WIDTH-1:0]   init_i,
    input  logic [NUMBERS-1:0][WIDTH-1:0]   inc_x_i,
    input  logic [NUMBERS-1:0][WIDTH-1:0]   inc_y_i,
    input  logic                            cmd_valid_i,
    input  logic [1:0]                      cmd_i,
    output logic                            cmd_ready_o,
    output logic                            done_o,
    output logic [NUMBERS-1:0][WIDTH-1:0]   cur_o,
    output logic [NUMBERS-1:0][WIDTH-1:0]   row_o
);

    localparam int BANKS  = (NUMBERS + ADDERS - 1) / ADDERS;
    localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1;

    typedef enum logic {S_IDLE, S_BUSY} state_t;
    typedef enum logic [1:0] {OP_STEP_X = 2'd0, OP_STEP_Y = 2'd1,
                              OP_RESTORE = 2'd2, OP_NOP = 2'd3} op_t;

    state_t                          state_q, state_d;
    logic [BANK_W-1:0]               bank_q, bank_d;
    logic                            step_y_q, step_y_d;
    logic                            done_q, done_d;
    logic [NUMBERS-1:0][WIDTH-1:0]   cur_q, cur_d;
    logic [NUMBERS-1:0][WIDTH-1:0]   row_q, row_d;
    logic [NUMBERS-1:0][WIDTH-1:0]   inc_x_q, inc_x_d;
    logic [NUMBERS-1:0][WIDTH-1:0]   inc_y_q, inc_y_d;

    logic [ADDERS-1:0][WIDTH-1:0]    add_a, add_b, add_sum;

    // Sum at WIDTH+1 bits; overflow shows as the two top bits disagreeing.
    function automatic logic [WIDTH-1:0] add_fold(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        if (SATURATE != 0 && s[WIDTH] != s[WIDTH-1]) begin
            return s[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
        return s[WIDTH-1:0];
    endfunction

    assign cmd_ready_o = !rst_i && !latch_i && (state_q == S_IDLE);
    assign done_o      = done_q;
    assign cur_o       = cur_q;
    assign row_o       = row_q;

    // Lane i is always served by adder i%ADDERS during bank i/ADDERS, so the
    // operand mux and write-back use only constant lane indices.
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < NUMBERS; i++) begin
            if (int'(bank_q) == i / ADDERS) begin
                add_a[i % ADDERS] = step_y_q ? row_q[i]   : cur_q[i];
                add_b[i % ADDERS] = step_y_q ? inc_y_q[i] : inc_x_q[i];
            end
        end
        for (int k = 0; k < ADDERS; k++) begin
            add_sum[k] = add_fold(add_a[k], add_b[k]);
        end
    end

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        step_y_d = step_y_q;
        done_d   = 1'b0;
        cur_d    = cur_q;
        row_d    = row_q;
        inc_x_d  = inc_x_q;
        inc_y_d  = inc_y_q;
        if (latch_i) begin
            cur_d   = init_i;
            row_d   = init_i;
            inc_x_d = inc_x_i;
            inc_y_d = inc_y_i;
            state_d = S_IDLE;
            bank_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        case (op_t'(cmd_i))
                            OP_STEP_X, OP_STEP_Y: begin
                                step_y_d = cmd_i[0];
                                state_d  = S_BUSY;
                                bank_d   = '0;
                            end
                            OP_RESTORE: begin
                                cur_d  = row_q;
                                done_d = 1'b1;
                            end
                            default: done_d = 1'b1;
                        endcase
                    end
                end
                S_BUSY: begin
                    for (int i = 0; i < NUMBERS; i++) begin
                        if (int'(bank_q) == i / ADDERS) begin
                            cur_d[i] = add_sum[i % ADDERS];
                            if (step_y_q) row_d[i] = add_sum[i % ADDERS];
                        end
                    end
                    if (bank_q == BANK_W'(BANKS - 1)) begin
                        state_d = S_IDLE;
                        bank_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        bank_d = bank_q + BANK_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    bank_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            bank_q   <= '0;
            step_y_q <= 1'b0;
            done_q   <= 1'b0;
            cur_q    <= '0;
            row_q    <= '0;
            inc_x_q  <= '0;
            inc_y_q  <= '0;
        end else begin
            state_q  <= state_d;
            bank_q   <= bank_d;
            step_y_q <= step_y_d;
            done_q   <= done_d;
            cur_q    <= cur_d;
            row_q    <= row_d;
            inc_x_q  <= inc_x_d;
            inc_y_q  <= inc_y_d;
        end
    end

endmodule

// File: tb/tb_saph_int_stepper.sv
// Bench for saph_int_stepper: three instances share one stimulus stream.
//   u 0: WIDTH 8, NUMBERS 4, ADDERS 2, wrap
//   u 1: WIDTH 8, NUMBERS 4, ADDERS 2, saturate
//   u 2: WIDTH 8, NUMBERS 4, ADDERS 3, wrap
// A command-level model computes each command's final result at accept time
// and releases it after the bank latency; cur/row are compared whenever no
// command is in flight, done/ready on every cycle.
module tb_saph_int_stepper;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, latch, cmd_valid;
    logic [1:0]           cmd;
    logic [N-1:0][W-1:0]  init_v, incx_v, incy_v;
    logic [N-1:0][W-1:0]  cur_w [NI];
    logic [N-1:0][W-1:0]  row_w [NI];
    logic                 ready_w [NI];
    logic                 done_w [NI];

    saph_int_stepper #(.WIDTH(W), .NUMBERS(N), .ADDERS(2), .SATURATE(0)) u_wrap (
        .clk_i(clk), .rst_i(rst), .latch_i(latch), .init_i(init_v), .inc_x_i(incx_v),
        .inc_y_i(incy_v), .cmd_valid_i(cmd_valid), .cmd_i(cmd), .cmd_ready_o(ready_w[0]),
        .done_o(done_w[0]), .cur_o(cur_w[0]), .row_o(row_w[0]));

    saph_int_stepper #(.WIDTH(W), .NUMBERS(N), .ADDERS(2), .SATURATE(1)) u_sat (
        .clk_i(clk), .rst_i(rst), .latch_i(latch), .init_i(init_v), .inc_x_i(incx_v),
        .inc_y_i(incy_v), .cmd_valid_i(cmd_valid), .cmd_i(cmd), .cmd_ready_o(ready_w[1]),
        .done_o(done_w[1]), .cur_o(cur_w[1]), .row_o(row_w[1]));

    saph_int_stepper #(.WIDTH(W), .NUMBERS(N), .ADDERS(3), .SATURATE(0)) u_a3 (
        .clk_i(clk), .rst_i(rst), .latch_i(latch), .init_i(init_v), .inc_x_i(incx_v),
        .inc_y_i(incy_v), .cmd_valid_i(cmd_valid), .cmd_i(cmd), .cmd_ready_o(ready_w[2]),
        .done_o(done_w[2]), .cur_o(cur_w[2]), .row_o(row_w[2]));

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int sx(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    function automatic int fold(input int v, input bit sat);
        int r;
        if (sat) return (v > 127) ? 127 : ((v < -128) ? -128 : v);
        r = v & 255;
        if (r > 127) r -= 256;
        return r;
    endfunction

    // ---------------- command-level model ----------------
    int m_cur [NI][N];
    int m_row [NI][N];
    int m_ix  [NI][N];
    int m_iy  [NI][N];
    int t_cur [NI][N];
    int t_row [NI][N];
    int m_busy [NI];
    bit m_done [NI];
    bit m_sat  [NI] = '{1'b0, 1'b1, 1'b0};
    int m_add  [NI] = '{2, 2, 3};

    initial begin
        for (int u = 0; u < NI; u++) begin
            m_busy[u] = 0;
            m_done[u] = 1'b0;
            for (int i = 0; i < N; i++) begin
                m_cur[u][i] = 0; m_row[u][i] = 0; m_ix[u][i] = 0; m_iy[u][i] = 0;
                t_cur[u][i] = 0; t_row[u][i] = 0;
            end
        end
    end

    always @(posedge clk) begin
        for (int u = 0; u < NI; u++) begin
            m_done[u] = 1'b0;
            if (rst) begin
                m_busy[u] = 0;
                for (int i = 0; i < N; i++) begin
                    m_cur[u][i] = 0; m_row[u][i] = 0; m_ix[u][i] = 0; m_iy[u][i] = 0;
                end
            end else if (latch) begin
                m_busy[u] = 0;
                for (int i = 0; i < N; i++) begin
                    m_cur[u][i] = sx(init_v[i]); m_row[u][i] = sx(init_v[i]);
                    m_ix[u][i]  = sx(incx_v[i]); m_iy[u][i]  = sx(incy_v[i]);
                end
            end else if (m_busy[u] > 0) begin
                m_busy[u]--;
                if (m_busy[u] == 0) begin
                    m_done[u] = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        m_cur[u][i] = t_cur[u][i]; m_row[u][i] = t_row[u][i];
                    end
                end
            end else if (cmd_valid) begin
                case (cmd)
                    2'd0: begin
                        for (int i = 0; i < N; i++) begin
                            t_cur[u][i] = fold(m_cur[u][i] + m_ix[u][i], m_sat[u]);
                            t_row[u][i] = m_row[u][i];
                        end
                        m_busy[u] = (N + m_add[u] - 1) / m_add[u];
                    end
                    2'd1: begin
                        for (int i = 0; i < N; i++) begin
                            t_row[u][i] = fold(m_row[u][i] + m_iy[u][i], m_sat[u]);
                            t_cur[u][i] = t_row[u][i];
                        end
                        m_busy[u] = (N + m_add[u] - 1) / m_add[u];
                    end
                    2'd2: begin
                        for (int i = 0; i < N; i++) m_cur[u][i] = m_row[u][i];
                        m_done[u] = 1'b1;
                    end
                    default: m_done[u] = 1'b1;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < NI; u++) begin
                check($sformatf("u%0d_done", u), int'(done_w[u]), int'(m_done[u]));
                check($sformatf("u%0d_ready", u), int'(ready_w[u]),
                      int'(!rst && !latch && m_busy[u] == 0));
                if (m_busy[u] == 0) begin
                    for (int i = 0; i < N; i++) begin
                        check($sformatf("u%0d_cur%0d", u, i), sx(cur_w[u][i]), m_cur[u][i]);
                        check($sformatf("u%0d_row%0d", u, i), sx(row_w[u][i]), m_row[u][i]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic next();
        @(negedge clk);
        #1;
    endtask

    task automatic load(input int a[4], input int b[4], input int c[4]);
        for (int i = 0; i < N; i++) begin
            init_v[i] = W'(a[i]);
            incx_v[i] = W'(b[i]);
            incy_v[i] = W'(c[i]);
        end
        latch = 1'b1;
        next();
        latch = 1'b0;
    endtask

    task automatic run_cmd(input logic [1:0] op, input int wait_n);
        cmd_valid = 1'b1;
        cmd       = op;
        next();
        cmd_valid = 1'b0;
        repeat (wait_n) next();
    endtask

    task automatic lit_cur(input string nm, input int u, input int e[4]);
        for (int i = 0; i < N; i++) check($sformatf("%s_cur%0d", nm, i), sx(cur_w[u][i]), e[i]);
    endtask

    task automatic lit_row(input string nm, input int u, input int e[4]);
        for (int i = 0; i < N; i++) check($sformatf("%s_row%0d", nm, i), sx(row_w[u][i]), e[i]);
    endtask

    int dcount;
    int rcount;

    initial begin
        rst = 1'b1; latch = 1'b0; cmd_valid = 1'b0; cmd = 2'd3;
        init_v = '0; incx_v = '0; incy_v = '0;
        next();
        chk_en = 1'b1;
        next();
        rst = 1'b0;
        next();
        // reset state
        lit_cur("t1", 0, '{0, 0, 0, 0});
        lit_row("t1", 0, '{0, 0, 0, 0});
        check("t1_done", int'(done_w[0]), 0);
        check("t1_ready", int'(ready_w[0]), 1);

        // STEP_X latency and partial-bank view
        load('{10, 20, 30, 40}, '{1, 2, 3, 4}, '{-5, 0, 5, 100});
        cmd_valid = 1'b1; cmd = 2'd0;
        next();
        cmd_valid = 1'b0;
        check("t2_ready_busy", int'(ready_w[0]), 0);
        next();
        lit_cur("t2_bank0", 0, '{11, 22, 30, 40});
        lit_cur("t2_a3_bank0", 2, '{11, 22, 33, 40});
        check("t2_done_mid", int'(done_w[0]), 0);
        check("t2_ready_mid", int'(ready_w[0]), 0);
        next();
        lit_cur("t2_final", 0, '{11, 22, 33, 44});
        check("t2_done", int'(done_w[0]), 1);
        check("t2_ready_done", int'(ready_w[0]), 1);

        // STEP_X, STEP_X, STEP_Y, then STEP_X and RESTORE
        run_cmd(2'd0, 2);
        run_cmd(2'd0, 2);
        run_cmd(2'd1, 2);
        lit_row("t3_wrap", 0, '{5, 20, 35, -116});
        lit_cur("t3_wrap", 0, '{5, 20, 35, -116});
        lit_row("t3_sat", 1, '{5, 20, 35, 127});
        run_cmd(2'd0, 2);
        lit_cur("t3_stepx", 0, '{6, 22, 38, -112});
        run_cmd(2'd2, 0);
        check("t3_restore_done", int'(done_w[0]), 1);
        lit_cur("t3_restore", 0, '{5, 20, 35, -116});
        next();
        check("t3_done_clear", int'(done_w[0]), 0);

        // back-to-back STEP_X with cmd_valid held
        dcount = 0; rcount = 0;
        cmd_valid = 1'b1; cmd = 2'd0;
        for (int c = 0; c < 9; c++) begin
            next();
            dcount += int'(done_w[2]);
            rcount += int'(ready_w[2]);
        end
        cmd_valid = 1'b0;
        check("t6_done_count", dcount, 3);
        check("t6_ready_count", rcount, 3);
        lit_cur("t6_a3", 2, '{8, 26, 44, -104});
        next();

        // saturation vs wrap
        load('{120, -120, 0, 0}, '{10, -10, 0, 0}, '{0, 0, 0, 0});
        run_cmd(2'd0, 2);
        lit_cur("t4_sat", 1, '{127, -128, 0, 0});
        lit_cur("t4_wrap", 0, '{-126, 126, 0, 0});

        // latch aborts an in-flight STEP_X
        load('{1, 2, 3, 4}, '{5, 5, 5, 5}, '{0, 0, 0, 0});
        cmd_valid = 1'b1; cmd = 2'd0;
        next();
        cmd_valid = 1'b0;
        init_v = {8'd10, 8'd9, 8'd8, 8'd7};
        latch = 1'b1;
        next();
        latch = 1'b0;
        lit_cur("t5", 0, '{7, 8, 9, 10});
        lit_row("t5", 0, '{7, 8, 9, 10});
        check("t5_done_abort", int'(done_w[0]), 0);
        next();
        check("t5_done_after", int'(done_w[0]), 0);
        check("t5_ready_after", int'(ready_w[0]), 1);

        // reset during a STEP_Y
        cmd_valid = 1'b1; cmd = 2'd1;
        next();
        cmd_valid = 1'b0;
        rst = 1'b1;
        next();
        rst = 1'b0;
        lit_cur("t7_rst", 0, '{0, 0, 0, 0});
        check("t7_done", int'(done_w[0]), 0);
        next();
        check("t7_done_after", int'(done_w[0]), 0);

        // NOP pulses done only
        run_cmd(2'd3, 0);
        check("t8_nop_done", int'(done_w[1]), 1);
        lit_cur("t8_nop", 1, '{0, 0, 0, 0});
        next();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
